// File: rtl/muldiv_seq_pkg.sv
// Shared defines for the mul/div sequencer: ALU op codes and FSM states.
// Imported by the sequencer top, its step datapath and the bench.
package muldiv_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALUOP_MULT  = 5'h18;
  localparam logic [4:0] ALUOP_MULTU = 5'h19;
  localparam logic [4:0] ALUOP_DIV   = 5'h1a;
  localparam logic [4:0] ALUOP_DIVU  = 5'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration.
// Purely combinational so it can be checked against a full multiplier.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         div_i,
  input  logic [2*W:0] acc_i,
  input  logic [W-1:0] opd_i,
  output logic [2*W:0] acc_o
);

  logic [W:0]   sum;
  logic [2*W:0] sh;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;

  always_comb begin
    sum    = acc_i[2*W:W] + (acc_i[0] ? {1'b0, opd_i} : '0);
    sh     = {acc_i[2*W-1:0], 1'b0};
    rem_sh = sh[2*W:W];
    diff   = rem_sh - {1'b0, opd_i};
    if (div_i) begin
      if (rem_sh >= {1'b0, opd_i}) begin
        acc_o = {1'b0, diff[W-1:0], sh[W-1:1], 1'b1};
      end else begin
        acc_o = {1'b0, rem_sh[W-1:0], sh[W-1:0]};
      end
    end else begin
      acc_o = {1'b0, sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One bit per cycle; MTHI/MTLO land only while idle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [4:0]       aluop_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             cancel_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH+1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d, acc_nx;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             op_ok, op_div, op_sgn;
  logic             accept;
  logic [WIDTH-1:0] mag0, mag1;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  logic             unused_carry;

  always_comb begin
    op_ok  = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    unique case (aluop_i)
      ALUOP_MULT:  begin op_ok = 1'b1; op_sgn = 1'b1; end
      ALUOP_MULTU: begin op_ok = 1'b1; end
      ALUOP_DIV:   begin op_ok = 1'b1; op_div = 1'b1; op_sgn = 1'b1; end
      ALUOP_DIVU:  begin op_ok = 1'b1; op_div = 1'b1; end
      default:     ;
    endcase
  end

  assign accept = (state_q == ST_IDLE) & start_i & ~cancel_i & op_ok;
  assign mag0   = (op_sgn & src0_i[WIDTH-1]) ? -src0_i : src0_i;
  assign mag1   = (op_sgn & src1_i[WIDTH-1]) ? -src1_i : src1_i;

  muldiv_step #(.W(WIDTH)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .opd_i (opd_q),
    .acc_o (acc_nx)
  );

  // With a zero divisor the remainder ends up as |dividend|, so the
  // normal remainder fix-up already restores src0 as issued.
  assign prod = neg_q  ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quo  = neg_q  ? -acc_q[WIDTH-1:0]   : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];
  assign unused_carry = acc_q[AW-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (cancel_i) state_d = ST_IDLE;
        else if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opd_d  = opd_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    div0_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (accept) begin
          cnt_d  = '0;
          div_d  = op_div;
          neg_d  = op_sgn & (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);
          rneg_d = op_sgn & op_div & src0_i[WIDTH-1];
          dz_d   = op_div & (src1_i == '0);
          acc_d  = {{(WIDTH+1){1'b0}}, op_div ? mag0 : mag1};
          opd_d  = op_div ? mag1 : mag0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_nx;
      end
      ST_FIX: begin
        if (!cancel_i) begin
          if (div_q) begin
            hi_d = rem;
            lo_d = dz_q ? '1 : quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          done_d = 1'b1;
          div0_d = dz_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opd_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opd_q  <= opd_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO pushed on issue,
// popped and compared on done_o.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  aluop;
  logic [31:0] src0, src1, wdata;
  logic        cancel, hi_we, lo_we;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .aluop_i  (aluop),
    .src0_i   (src0),
    .src1_i   (src1),
    .cancel_i (cancel),
    .hi_we_i  (hi_we),
    .lo_we_i  (lo_we),
    .wdata_i  (wdata),
    .busy_o   (busy),
    .done_o   (done),
    .div0_o   (div0),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  function automatic exp_t model(logic [4:0] op, logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    logic signed [63:0] p;
    logic [63:0] u;
    int sa, sb;
    e = '0;
    case (op)
      ALUOP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        e.hi = u[63:32]; e.lo = u[31:0];
      end
      ALUOP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      ALUOP_DIVU: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      ALUOP_DIV: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          e.lo = 32'h8000_0000; e.hi = 0;
        end else begin
          sa = a; sb = b;
          e.lo = sa / sb; e.hi = sa % sb;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    aluop = op; src0 = a; src1 = b; start = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        return;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; cancel = 0; hi_we = 0; lo_we = 0;
    aluop = 0; src0 = 0; src1 = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, div0});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [4:0]  ops[3] = '{ALUOP_MULTU, ALUOP_MULT, ALUOP_MULT};
    logic [31:0] as[3]  = '{32'hffff_ffff, 32'hffff_fffd, 32'h8000_0000};
    logic [31:0] bs[3]  = '{32'hffff_ffff, 32'd5, 32'h8000_0000};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, bc);
      checks++;
      if (lat != 33) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat);
      end
      if (i == 0) begin
        checks++;
        if (bc != 33) begin
          errors++;
          $display("FAIL mul_busy_cycles: got %0d expected 33", bc);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b expected 0", busy);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo, div0} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("FAIL mul_result[%0d]: got %h_%h/%b expected %h_%h/%b",
                 i, hi, lo, div0, e.hi, e.lo, e.dz);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops[5] = '{ALUOP_DIV, ALUOP_DIVU, ALUOP_DIV,
                            ALUOP_DIVU, ALUOP_DIV};
    logic [31:0] as[5]  = '{32'hffff_fff9, 32'd7, 32'h8000_0000,
                            32'h0000_1234, 32'hffff_fff9};
    logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hffff_ffff, 32'd0, 32'd0};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, bc);
      checks++;
      if (lat != 33) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo, div0} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("FAIL div_result[%0d]: got %h_%h/%b expected %h_%h/%b",
                 i, hi, lo, div0, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[4] = '{ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU};
    logic [31:0] a, b;
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 4 == 1) b = -b;
      issue(ops[$urandom_range(0, 3)], a, b);
      wait_done(lat, bc);
      e = exp_q.pop_front();
      checks++;
      if (lat != 33 || {hi, lo, div0} !== {e.hi, e.lo, e.dz}) begin
        errors++;
        $display("FAIL rand[%0d]: got %h_%h/%b lat %0d expected %h_%h/%b",
                 i, hi, lo, div0, lat, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc, nd;
    exp_t e;
    issue(ALUOP_MULTU, 32'd2, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    aluop = ALUOP_DIVU; src0 = 32'd100; src1 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo} || lat != 23) begin
      errors++;
      $display("FAIL ignore_start: got %h_%h lat %0d expected %h_%h lat 23",
               hi, lo, lat, e.hi, e.lo);
    end
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL ignore_no_queue: got %0d active cycles expected 0", nd);
    end
  endtask

  task automatic test_mt_idle();
    hi_we = 1'b1; wdata = 32'ha5a5_a5a5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'ha5a5_a5a5) begin
      errors++;
      $display("FAIL mthi_idle: got %h expected a5a5a5a5", hi);
    end
    lo_we = 1'b1; wdata = 32'h5a5a_5a5a;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== 64'ha5a5_a5a5_5a5a_5a5a) begin
      errors++;
      $display("FAIL mtlo_idle: got %h_%h expected a5a5a5a5_5a5a5a5a", hi, lo);
    end
  endtask

  task automatic test_cancel();
    int nd;
    aluop = ALUOP_MULTU; src0 = 32'd7; src1 = 32'd9;
    start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_blocks_start: got busy %b expected 0", busy);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle: got busy %b expected 0", busy);
    end
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd != 0 || {hi, lo} !== 64'ha5a5_a5a5_5a5a_5a5a) begin
      errors++;
      $display("FAIL cancel_hold: got %h_%h done %0d expected a5a5a5a5_5a5a5a5a done 0",
               hi, lo, nd);
    end
  endtask

  task automatic test_mt_busy();
    int lat, bc;
    exp_t e;
    issue(ALUOP_MULTU, 32'd4, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hdead_beef;
    @(posedge clk); #1;
    lo_we = 1'b0; hi_we = 1'b0;
    checks++;
    if ({hi, lo} !== 64'ha5a5_a5a5_5a5a_5a5a) begin
      errors++;
      $display("FAIL mt_busy_ignored: got %h_%h expected a5a5a5a5_5a5a5a5a",
               hi, lo);
    end
    wait_done(lat, bc);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL mt_busy_result: got %h_%h expected %h_%h",
               hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_mthi_start();
    int lat, bc;
    exp_t e;
    hi_we = 1'b1; wdata = 32'hcafe_f00d;
    issue(ALUOP_MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    checks++;
    if ({busy, hi} !== {1'b1, 32'hcafe_f00d}) begin
      errors++;
      $display("FAIL mthi_with_start: got %b/%h expected 1/cafef00d", busy, hi);
    end
    wait_done(lat, bc);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL mthi_overwritten: got %h_%h expected %h_%h",
               hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_midop();
    issue(ALUOP_MULTU, 32'hffff_ffff, 32'hffff_ffff);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div0, hi, lo} !== 67'h0) begin
      errors++;
      $display("FAIL reset_midop: got %b%b%b %h_%h expected all 0",
               busy, done, div0, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    exp_t e;
    issue(ALUOP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bc);
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL b2b_first: got %h_%h expected %h_%h",
               hi, lo, e.hi, e.lo);
    end
    issue(ALUOP_MULT, 32'hffff_fffd, 32'd5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy %b expected 1", busy);
    end
    wait_done(lat, bc);
    e = exp_q.pop_front();
    checks++;
    if (lat != 33 || {hi, lo} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL b2b_second: got %h_%h lat %0d expected %h_%h lat 33",
               hi, lo, lat, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_ignore_start();
    test_mt_idle();
    test_cancel();
    test_mt_busy();
    test_mthi_start();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers. It accepts one MULT, MULTU, DIV or DIVU operation at a time from the issue stage. It runs a one-bit-per-cycle shift-add or restoring-divide loop and writes the 64-bit result into HI/LO, so the main ALU keeps only single-cycle ops on the critical path. MTHI/MTLO writes also go through this block.

## Interface
- WIDTH, 32, operand width. Iteration count equals WIDTH.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request to begin an operation; sampled only while busy_o=0.
- aluop_i  in  5  operation select: ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV or ALUOP_DIVU. Any other code with start_i is ignored.
- src0_i  in  WIDTH  multiplicand / dividend (rs).
- src1_i  in  WIDTH  multiplier / divisor (rt).
- cancel_i  in  1  flush; aborts any in-flight operation.
- hi_we_i, lo_we_i  in  1 each  MTHI / MTLO write enables.
- wdata_i  in  WIDTH  MTHI/MTLO data.
- busy_o  out  1  operation in flight; issue stage stalls MFHI/MFLO and new mul/div while high.
- done_o  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div0_o  out  1  pulses with done_o when a divide had src1_i==0.
- hi_o, lo_o  out  WIDTH  current HI/LO register values.

## Operation
- **FSM states:** IDLE, RUN, FIX.
- **IDLE → RUN** on start_i with a valid aluop. At that edge the block latches:
  - the op
  - operand magnitudes (two's-complement absolute value for MULT/DIV)
  - result sign flags: quotient/product sign = src0[31]^src1[31]; remainder sign = src0[31]
  - a divide-by-zero flag
  - cnt=0
- **RUN:** one iteration per cycle; cnt increments; RUN → FIX when cnt==WIDTH-1.
  - Multiply: 65-bit accumulator {carry,hi,lo}. If lo[0], add the multiplicand to the upper half, then shift right 1.
  - Divide: restoring divide. Shift {rem,quo} left 1. If rem ≥ divisor, subtract and set quo[0]=1.
- **FIX:** apply sign correction, write HI/LO, pulse done_o and div0_o, return to IDLE.
  - MULT: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient (LO) if the signs differ; negate the remainder (HI) if the dividend was negative.
  - Result semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- **Divide by zero:** HI=src0_i as issued, LO=all-ones, div0_o=1, for both DIV and DIVU. The loop still runs full length.
- **DIV overflow:** 0x80000000 / -1 wraps to LO=0x80000000, HI=0. No flag.
- **MTHI/MTLO:**
  - Applied at the edge only while IDLE.
  - Ignored while RUN/FIX.
  - If applied in the same edge as an accepted start, the write lands and is later overwritten by the result.
- **start_i while busy:** ignored, with no queueing.
- **cancel_i:** in RUN or FIX, return to IDLE at the next edge. HI/LO are unchanged and done_o stays 0. In IDLE, cancel_i blocks a same-cycle start_i.

## Timing
- **Reset values:** state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, div0_o=0, cnt=0. Reset asserted mid-operation discards it immediately.
- **Latency:** start accepted at edge E0.
  - busy_o=1 after E0 through E33.
  - E1..E32 perform the 32 iterations; state=FIX after E32.
  - At E33, HI/LO are written and state returns to IDLE.
  - Result and done_o are visible after E33, i.e. 33 cycles after acceptance, with busy_o=0 in that same cycle.
- **Back-to-back:** a new start_i can be accepted in the cycle done_o is high.
- **Outputs:** busy_o, done_o, div0_o, hi_o and lo_o are all registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared defines:** ALUOP_* codes come from the shared defines file. FSM state encodings (IDLE/RUN/FIX) are added there too.
- **Sub-module muldiv_step:** combinational single iteration. Inputs: op class, 65-bit accumulator, operand magnitude. Output: next accumulator. Also reused for formal equivalence against a full-width multiplier.
- **Top level:** FSM, counter, sign latches, HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 33 cycles after acceptance; busy_o high 33 cycles.
- MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234, div0_o pulses with done_o.
- start_i at cycle 10 of a running op → ignored. cancel_i at cycle 20 → IDLE next edge, HI/LO keep prior values, no done_o. rst_n_i low mid-op → all outputs 0 immediately.
- MTHI 0xA5A5A5A5 in IDLE → hi_o updated next cycle. MTLO while busy → ignored. MTHI together with an accepted MULTU 2×3 → final HI=0, LO=6.
